// File: rtl/univ_shift_reg.sv
// Multi-cycle universal shift/rotate register with start/busy/done handshake.
// Define SHIFT_HOLD_EN to add a hold input that stalls an active operation.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
`ifdef SHIFT_HOLD_EN
  input  logic             hold,
`endif
  output logic [WIDTH-1:0] out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, next_state;
  logic [1:0]       mode_q;
  logic [AMT_W-1:0] count;
  logic             stall;
  logic             accept;
  logic             step;
  logic             last_step;
  logic [WIDTH-1:0] shifted;
  logic             shifted_bit;

`ifdef SHIFT_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  assign accept    = (state == IDLE) && start;
  assign step      = (state == SHIFT) && !stall;
  assign last_step = step && (count == AMT_W'(1));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && (amount != '0)) next_state = SHIFT;
      SHIFT:   if (last_step)                next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  // One-position step; logical modes fill from serial_in, rotates recirculate.
  always_comb begin
    shifted     = out;
    shifted_bit = 1'b0;
    case (mode_q)
      2'b00: begin
        shifted     = {out[WIDTH-2:0], serial_in};
        shifted_bit = out[WIDTH-1];
      end
      2'b01: begin
        shifted     = {serial_in, out[WIDTH-1:1]};
        shifted_bit = out[0];
      end
      2'b10: begin
        shifted     = {out[WIDTH-2:0], out[WIDTH-1]};
        shifted_bit = out[WIDTH-1];
      end
      default: begin
        shifted     = {out[0], out[WIDTH-1:1]};
        shifted_bit = out[0];
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out        <= '0;
      serial_out <= 1'b0;
      done       <= 1'b0;
      mode_q     <= 2'b00;
      count      <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        out        <= load_data;
        serial_out <= 1'b0;
        mode_q     <= mode;
        count      <= amount;
        done       <= (amount == '0);
      end else if (step) begin
        out        <= shifted;
        serial_out <= shifted_bit;
        count      <= count - AMT_W'(1);
        done       <= last_step;
      end
    end
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised multi-cycle universal shift/rotate register. It is the successor to the fixed 3-bit D-register with asynchronous clear.
- Loads a WIDTH-bit word, then shifts or rotates it by a programmed amount, one bit position per clock.
- Uses a start/busy/done handshake.
- Used by datapath blocks that need serialised shifting without a barrel shifter.

Parameters:
- WIDTH, 8: data word width in bits, ≥2.
- AMT_W, 4: width of the shift-amount field.

Ports:
- clock  in  1  rising-edge clock
- nreset  in  1  asynchronous active-low reset
- start  in  1  request a new operation; sampled only when idle
- mode  in  2  00 logical shift left, 01 logical shift right, 10 rotate left, 11 rotate right
- amount  in  AMT_W  number of 1-bit steps, 0 to 2^AMT_W-1
- load_data  in  WIDTH  initial word
- serial_in  in  1  fill bit for vacated position in logical modes; sampled every shift cycle
- hold  in  1  present only with SHIFT_HOLD_EN; freezes an active operation
- out  out  WIDTH  register contents
- serial_out  out  1  last bit shifted or rotated out
- busy  out  1  high while shifting
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: nreset is asynchronous, active-low; clock is clock.
  - While nreset=0: out=0, serial_out=0, busy=0, done=0, FSM=IDLE, internal count=0, latched mode=00.
  - Assertion mid-operation aborts it immediately. No completion pulse is produced after release.
- FSM states:
  - IDLE (busy=0)
  - SHIFT (busy=1)
  - done is a registered pulse output, not a state.
- Start (edge where start=1 and busy=0): out<=load_data, serial_out<=0, mode latched, count<=amount.
  - amount=0: done<=1 on the same edge; stay IDLE; busy never rises.
  - amount>0: busy<=1, go to SHIFT, done<=0.
- Each edge in SHIFT performs one step and count<=count-1. The shifted-out bit goes to serial_out.
  - Logical left: out<={out[WIDTH-2:0],serial_in}; serial_out<=out[WIDTH-1].
  - Logical right: out<={serial_in,out[WIDTH-1:1]}; serial_out<=out[0].
  - Rotate left: out<={out[WIDTH-2:0],out[WIDTH-1]}; serial_out<=out[WIDTH-1].
  - Rotate right: out<={out[0],out[WIDTH-1:1]}; serial_out<=out[0].
- Completion: the edge where count==1 performs the final step, then busy<=0, done<=1, FSM=IDLE.
  - Total latency: amount+1 edges from start sampled to done visible.
  - busy stays high for exactly amount cycles.
- done:
  - Cleared on the next edge unless a new amount=0 start occurs on that edge.
  - A start with amount>0 in the done cycle is accepted and clears done.
- start while busy=1: ignored. Latched mode/amount and out are unaffected.
- mode/amount/load_data changes while busy: no effect (latched at start).
- amount ≥ WIDTH:
  - Rotates wrap modulo WIDTH naturally.
  - Logical shifts continue; out fills entirely from the serial_in stream.
- out and serial_out hold their values in IDLE.

Optional Feature:
- Macro: SHIFT_HOLD_EN.
- Defined: hold port exists. hold=1 in SHIFT freezes out, serial_out and count; busy stays 1. hold has no effect in IDLE or on start acceptance.
- Undefined: no hold port; shifting is never stalled.

Test Plan:
- WIDTH=8, load 8'hA5, mode 00, amount 3, serial_in=0 -> out 4A,94,28 on successive edges; busy 3 cycles; done one pulse; final out=8'h28, serial_out=1.
- load 8'hA5, mode 11, amount 4 -> out D2,69,B4,5A; final out=8'h5A, serial_out=0; done one cycle after the 4th shift edge.
- load 8'h3C, amount 0, mode 10 -> out=8'h3C and done=1 after the start edge; busy never 1; done low next edge.
- load 8'h00, mode 01, amount 10, serial_in=1 -> out=8'hFF after 8 steps and unchanged through step 10; serial_out=1; busy 10 cycles.
- During amount 5 operation, pulse start with different load_data at cycle 2 -> ignored; result matches the original operation. Then drop nreset mid-operation -> out=0, busy=0, done=0 immediately; no done after release.
- With SHIFT_HOLD_EN: load 8'h81, rotate left, amount 2, hold=1 for 3 cycles after the first step -> out stays 8'h03 during hold; final out=8'h06; busy 5 cycles.
